// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Module      : mips_defs (package)
// Description : Shared definitions for the MIPS pipeline control slice:
//               controller state encodings, HALT opcode and the default
//               number of drain cycles after HALT leaves ID.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Primary opcode of the HALT instruction, decoded in ID.
  localparam logic [5:0] c_OP_HALT = 6'h3F;

  // Advancing cycles needed to retire HALT once it leaves ID (ID->EX->MEM->WB).
  localparam int c_DRAIN_CYCLES = 3;

  // Controller states; the encoding is visible on o_State.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use hazard detection. Flags the case where the load
//               in EX writes a register read by the instruction in ID.
// Ports       : i_ID_EX_MemRead - load in EX
//               i_ID_EX_Rt      - load destination register
//               i_IF_ID_Rs/Rt   - source registers of the instruction in ID
//               o_Hazard        - load-use hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit (
  input  logic       i_ID_EX_MemRead,
  input  logic [4:0] i_ID_EX_Rt,
  input  logic [4:0] i_IF_ID_Rs,
  input  logic [4:0] i_IF_ID_Rt,
  output logic       o_Hazard
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign o_Hazard = i_ID_EX_MemRead && (i_ID_EX_Rt != 5'd0) &&
                    ((i_ID_EX_Rt == i_IF_ID_Rs) || (i_ID_EX_Rt == i_IF_ID_Rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline run/step/halt controller. Sequences IDLE, RUN,
//               PAUSE/STEP (debug single-step), DRAIN (retire HALT) and DONE,
//               generates stall/flush/bubble controls and counts advancing
//               cycles.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               i_Start, i_Step_Mode - launch; mode sampled with i_Start
//               i_Step               - single-step pulse while paused
//               i_Halt_ID            - HALT decoded in ID
//               i_ID_EX_MemRead, i_ID_EX_Rt, i_IF_ID_Rs, i_IF_ID_Rt - hazard
//               i_Branch_Taken       - taken branch/jump resolved in ID
//               o_Stall, o_IF_Flush, o_ID_EX_Bubble, o_Halt - pipeline ctrl
//               o_State, o_Cycles, o_Done - status
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import mips_defs::*;
#(
  parameter int DRAIN_CYCLES = c_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_Start,
  input  logic        i_Step_Mode,
  input  logic        i_Step,
  input  logic        i_Halt_ID,
  input  logic        i_ID_EX_MemRead,
  input  logic [4:0]  i_ID_EX_Rt,
  input  logic [4:0]  i_IF_ID_Rs,
  input  logic [4:0]  i_IF_ID_Rt,
  input  logic        i_Branch_Taken,
  output logic        o_Stall,
  output logic        o_IF_Flush,
  output logic        o_ID_EX_Bubble,
  output logic        o_Halt,
  output logic [2:0]  o_State,
  output logic [31:0] o_Cycles,
  output logic        o_Done
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_drain_cnt;
  logic [31:0] w_next_drain;
  logic [31:0] r_cycles;
  logic        w_hazard;

  hazard_unit u_hazard (
    .i_ID_EX_MemRead (i_ID_EX_MemRead),
    .i_ID_EX_Rt      (i_ID_EX_Rt),
    .i_IF_ID_Rs      (i_IF_ID_Rs),
    .i_IF_ID_Rt      (i_IF_ID_Rt),
    .o_Hazard        (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 32'd0;
      r_cycles    <= 32'd0;
    end else begin
      r_state     <= w_next_state;
      r_drain_cnt <= w_next_drain;
      // Stalled cycles still advance the clocked pipeline, so they count.
      if (!o_Halt) begin
        r_cycles <= r_cycles + 32'd1;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_drain   = r_drain_cnt;
    o_Stall        = 1'b0;
    o_IF_Flush     = 1'b0;
    o_ID_EX_Bubble = 1'b0;
    o_Halt         = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (i_Start) begin
          w_next_state = i_Step_Mode ? ST_PAUSE : ST_RUN;
        end
      end

      ST_PAUSE: begin
        if (i_Step) begin
          w_next_state = ST_STEP;
        end
      end

      ST_RUN, ST_STEP: begin
        o_Halt = 1'b0;
        // Load-use stall takes priority over a branch flush: the branch
        // is re-evaluated once the dependency clears.
        if (w_hazard) begin
          o_Stall        = 1'b1;
          o_ID_EX_Bubble = 1'b1;
        end else if (i_Branch_Taken) begin
          o_IF_Flush = 1'b1;
        end
        // HALT only leaves ID when ID is not held by a stall.
        if (i_Halt_ID && !w_hazard) begin
          w_next_state = ST_DRAIN;
          w_next_drain = 32'(DRAIN_CYCLES);
        end else if (r_state == ST_STEP) begin
          w_next_state = ST_PAUSE;
        end
      end

      ST_DRAIN: begin
        o_Halt     = 1'b0;
        // Keep fetching NOPs so nothing past HALT enters the pipe.
        o_IF_Flush = 1'b1;
        if (r_drain_cnt <= 32'd1) begin
          w_next_drain = 32'd0;
          w_next_state = ST_DONE;
        end else begin
          w_next_drain = r_drain_cnt - 32'd1;
        end
      end

      ST_DONE: begin
        w_next_state = ST_DONE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign o_State  = r_state;
  assign o_Cycles = r_cycles;
  assign o_Done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. A behavioural model
//               tracks the controller mode and cycle count; every negedge
//               the DUT outputs are compared against it, and directed
//               scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_STEP  = 3;
  localparam int M_DRAIN = 4;
  localparam int M_DONE  = 5;
  localparam int D       = 3;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, step, halt_id, memread, br;
  logic [4:0]  ex_rt, rs, rt;
  logic        stall, flush, bubble, halt, done;
  logic [2:0]  state;
  logic [31:0] cycles;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  int          m_mode = M_IDLE;
  int          m_left = 0;
  logic [31:0] m_cycles = 32'd0;

  pipeline_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_Start         (start),
    .i_Step_Mode     (step_mode),
    .i_Step          (step),
    .i_Halt_ID       (halt_id),
    .i_ID_EX_MemRead (memread),
    .i_ID_EX_Rt      (ex_rt),
    .i_IF_ID_Rs      (rs),
    .i_IF_ID_Rt      (rt),
    .i_Branch_Taken  (br),
    .o_Stall         (stall),
    .o_IF_Flush      (flush),
    .o_ID_EX_Bubble  (bubble),
    .o_Halt          (halt),
    .o_State         (state),
    .o_Cycles        (cycles),
    .o_Done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard();
    return memread && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));
  endfunction

  function automatic logic m_halted();
    return (m_mode == M_IDLE) || (m_mode == M_PAUSE) || (m_mode == M_DONE);
  endfunction

  function automatic logic m_active();
    return (m_mode == M_RUN) || (m_mode == M_STEP);
  endfunction

  function automatic logic [2:0] m_code();
    case (m_mode)
      M_RUN:   return mips_defs::ST_RUN;
      M_PAUSE: return mips_defs::ST_PAUSE;
      M_STEP:  return mips_defs::ST_STEP;
      M_DRAIN: return mips_defs::ST_DRAIN;
      M_DONE:  return mips_defs::ST_DONE;
      default: return mips_defs::ST_IDLE;
    endcase
  endfunction

  // Behavioural model: advances on each rising edge from the inputs applied.
  always @(posedge clk) begin
    if (rst) begin
      m_mode   = M_IDLE;
      m_left   = 0;
      m_cycles = 32'd0;
    end else begin
      if (!m_halted()) m_cycles = m_cycles + 32'd1;
      case (m_mode)
        M_IDLE:  if (start) m_mode = step_mode ? M_PAUSE : M_RUN;
        M_PAUSE: if (step) m_mode = M_STEP;
        M_RUN, M_STEP: begin
          if (halt_id && !m_hazard()) begin
            m_mode = M_DRAIN;
            m_left = D;
          end else if (m_mode == M_STEP) begin
            m_mode = M_PAUSE;
          end
        end
        M_DRAIN: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_DONE;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_state",  {29'd0, state},  {29'd0, m_code()});
      check("cmp_halt",   {31'd0, halt},   {31'd0, m_halted()});
      check("cmp_stall",  {31'd0, stall},  {31'd0, m_active() && m_hazard()});
      check("cmp_bubble", {31'd0, bubble}, {31'd0, m_active() && m_hazard()});
      check("cmp_flush",  {31'd0, flush},
            {31'd0, (m_mode == M_DRAIN) || (m_active() && !m_hazard() && br)});
      check("cmp_done",   {31'd0, done},   {31'd0, m_mode == M_DONE});
      check("cmp_cycles", cycles, m_cycles);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    rst = 1; start = 0; step_mode = 0; step = 0; halt_id = 0;
    memread = 0; br = 0; ex_rt = 0; rs = 0; rt = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_state",  {29'd0, state}, {29'd0, mips_defs::ST_IDLE});
    check("rst_halt",   {31'd0, halt}, 32'd1);
    check("rst_cycles", cycles, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);

    // Continuous run.
    rst = 0; start = 1; step_mode = 0;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    check("run_state", {29'd0, state}, {29'd0, mips_defs::ST_RUN});
    check("run_halt",  {31'd0, halt}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("cycles10", cycles, 32'd10);

    // Load-use hazard beats branch and blocks HALT leaving ID.
    memread = 1; ex_rt = 5; rs = 5; br = 1; halt_id = 1; step = 1; start = 1;
    @(negedge clk);
    check("hz_stall",  {31'd0, stall},  32'd1);
    check("hz_bubble", {31'd0, bubble}, 32'd1);
    check("hz_flush",  {31'd0, flush},  32'd0);
    @(posedge clk); #1;
    halt_id = 0; ex_rt = 0; step = 0; start = 0;
    @(negedge clk);
    check("hz_held_run", {29'd0, state}, {29'd0, mips_defs::ST_RUN});
    check("rt0_stall",   {31'd0, stall}, 32'd0);
    check("rt0_flush",   {31'd0, flush}, 32'd1);
    @(posedge clk); #1;

    // Mixed directed patterns, checked by the per-cycle comparison.
    for (int i = 0; i < 8; i++) begin
      memread = i[0];
      ex_rt   = i[1] ? 5'd9 : 5'd3;
      rs      = i[2] ? 5'd9 : 5'd1;
      rt      = 5'd3;
      br      = i[1] ^ i[2];
      @(posedge clk); #1;
    end
    memread = 0; br = 0; ex_rt = 0; rs = 0; rt = 0;

    // HALT -> DRAIN for D cycles -> DONE (sticky).
    halt_id = 1;
    @(posedge clk); #1; halt_id = 0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk);
      check("drain_state", {29'd0, state}, {29'd0, mips_defs::ST_DRAIN});
      check("drain_flush", {31'd0, flush}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("done_state", {29'd0, state}, {29'd0, mips_defs::ST_DONE});
    check("done_done",  {31'd0, done}, 32'd1);
    check("done_halt",  {31'd0, halt}, 32'd1);
    start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    check("done_sticky", {29'd0, state}, {29'd0, mips_defs::ST_DONE});

    // Step mode; i_Start with i_Step in IDLE -> PAUSE, not STEP.
    rst = 1;
    @(posedge clk); #1; rst = 0;
    start = 1; step_mode = 1; step = 1;
    @(posedge clk); #1; start = 0; step = 0;
    @(negedge clk);
    check("pause_state", {29'd0, state}, {29'd0, mips_defs::ST_PAUSE});
    low = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1;
      @(posedge clk); #1; step = 0;
      repeat (3) begin
        @(negedge clk);
        if (!halt) low++;
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("step_low_cycles", low, 32'd3);
    check("step_cycles",     cycles, 32'd3);
    check("step_back_pause", {29'd0, state}, {29'd0, mips_defs::ST_PAUSE});

    // HALT during STEP, then reset in the 2nd DRAIN cycle.
    step = 1;
    @(posedge clk); #1; step = 0; halt_id = 1;
    @(negedge clk);
    check("step_state", {29'd0, state}, {29'd0, mips_defs::ST_STEP});
    @(posedge clk); #1; halt_id = 0;
    @(negedge clk);
    check("step_drain", {29'd0, state}, {29'd0, mips_defs::ST_DRAIN});
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("abort_state",  {29'd0, state}, {29'd0, mips_defs::ST_IDLE});
    check("abort_cycles", cycles, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);

    // Cycle counter wrap.
    m_cycles = 32'hFFFFFFFF;
    force dut.r_cycles = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.r_cycles;
    start = 1; step_mode = 0;
    @(posedge clk); #1; start = 0;
    @(negedge clk);
    check("wrap_pre", cycles, 32'hFFFFFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_zero", cycles, 32'h00000000);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_one", cycles, 32'h00000001);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
